// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs instruction field descriptors into 32-bit ARMv4 instruction words.
// The resulting words are streamed into instruction memory through a simple
// sequential write port. This block is the inverse of the core's instruction
// decoder. It sits between the host/debug message interface and the imem
// write side, and it loads a program while the core is held in halt.
//
// Parameters
//   ADDR_W     imem word-address width; memory depth = 2**ADDR_W words
//   BASE_ADDR  first word address written after start
//
// Ports
//   clk, rst_n   rising-edge clock; asynchronous active-low reset
//   start        1-cycle pulse: clear count, (re)enter LOAD (highest priority)
//   in_valid     descriptor valid
//   in_ready     descriptor can be accepted (LOAD and memory not yet full)
//   in_last      marks the final descriptor of the program
//   in_op        00 DP-reg, 01 DP-imm, 10 LDR/STR, 11 B
//   in_cond      condition field           -> [31:28]
//   in_cmd       DP opcode                 -> [24:21]
//   in_s         DP S bit                  -> [20]
//   in_l         load/store L bit          -> [20]
//   in_rn        Rn                        -> [19:16]
//   in_rd        Rd                        -> [15:12]
//   in_rm        Rm (DP-reg only)          -> [3:0]
//   in_imm12     DP rot4:imm8 or memory offset12
//   in_imm24     branch word offset
//   imem_we      write strobe, one cycle per word
//   imem_addr    word address of the current write
//   imem_wdata   encoded instruction of the current write
//   count        words issued since the last start (saturates at 2**ADDR_W)
//   done         program fully issued; high in DONE with no write in flight
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_l,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [11:0]       in_imm12,
    input  logic [23:0]       in_imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   LAST_CNT  = DEPTH_CNT - (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    localparam logic [1:0] OP_DP_REG = 2'b00;
    localparam logic [1:0] OP_DP_IMM = 2'b01;
    localparam logic [1:0] OP_MEM    = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;

    logic                ready;
    logic                accept;
    logic [31:0]         enc_word;

    // ------------------------------------------------------------------
    // Encoder. Each op builds its word only from the fields it owns. Fields
    // belonging to other ops (a stray imm12 on a DP-reg descriptor, for
    // example) never reach the output word.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // that no path leaves it unassigned, which would infer a latch.
        enc_word = '0;
        case (in_op)
            OP_DP_REG: enc_word = {in_cond, 3'b000, in_cmd, in_s, in_rn, in_rd,
                                   8'h00, in_rm};
            OP_DP_IMM: enc_word = {in_cond, 3'b001, in_cmd, in_s, in_rn, in_rd,
                                   in_imm12};
            // Immediate offset, pre-indexed, up, word, no write-back.
            OP_MEM:    enc_word = {in_cond, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0,
                                   in_l, in_rn, in_rd, in_imm12};
            OP_BRANCH: enc_word = {in_cond, 4'b1010, in_imm24};
            default:   enc_word = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control. count_q is bumped on the accept edge, in the same edge that
    // raises imem_we. It therefore already includes the word in flight, so
    // "count + pending < depth" reduces to count_q < depth.
    // ------------------------------------------------------------------
    assign ready  = (state_q == S_LOAD) && (count_q < DEPTH_CNT);
    assign accept = in_valid && ready && !start;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (start) begin
            // A write launched on the previous edge is already on the port at
            // its original address. Only the bookkeeping restarts here.
            state_d = S_LOAD;
            count_d = '0;
        end else if (accept) begin
            imem_we_d    = 1'b1;
            // Word n lands at BASE + n; the ADDR_W-bit add wraps modulo depth.
            imem_addr_d  = BASE + count_q[ADDR_W-1:0];
            imem_wdata_d = enc_word;
            count_d      = count_q + ONE_CNT;
            // The accept that fills memory ends the load even without in_last.
            if (in_last || (count_q == LAST_CNT)) begin
                state_d = S_DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign in_ready   = ready;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    // done waits until the final word has left the write port.
    assign done       = (state_q == S_DONE) && !imem_we_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Directed testbench for instr_encoder_loader with ADDR_W=6 and BASE_ADDR=0.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, after the registered outputs have settled.
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        in_op;
    logic [3:0]        in_cond;
    logic [3:0]        in_cmd;
    logic              in_s;
    logic              in_l;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [3:0]        in_rm;
    logic [11:0]       in_imm12;
    logic [23:0]       in_imm24;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_op      (in_op),
        .in_cond    (in_cond),
        .in_cmd     (in_cmd),
        .in_s       (in_s),
        .in_l       (in_l),
        .in_rn      (in_rn),
        .in_rd      (in_rd),
        .in_rm      (in_rm),
        .in_imm12   (in_imm12),
        .in_imm24   (in_imm24),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_op    = 2'b00;
        in_cond  = 4'h0;
        in_cmd   = 4'h0;
        in_s     = 1'b0;
        in_l     = 1'b0;
        in_rn    = 4'h0;
        in_rd    = 4'h0;
        in_rm    = 4'h0;
        in_imm12 = 12'h000;
        in_imm24 = 24'h000000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // DP-imm ADD r2, r1, #5 with cond AL -> 0xE2812005.
    task automatic drive_add();
        in_valid = 1'b1; in_last = 1'b0; in_op = 2'b01; in_cond = 4'hE;
        in_cmd = 4'h4; in_s = 1'b0; in_rn = 4'h1; in_rd = 4'h2;
        in_rm = 4'h0; in_imm12 = 12'h005; in_imm24 = 24'h0;
    endtask

    task automatic drive_mem(input logic l);
        in_valid = 1'b1; in_last = 1'b0; in_op = 2'b10; in_cond = 4'hE;
        in_cmd = 4'hF; in_s = 1'b1; in_l = l; in_rn = 4'h3; in_rd = 4'h4;
        in_rm = 4'hF; in_imm12 = 12'h008; in_imm24 = 24'hABCDEF;
    endtask

    task automatic drive_b(input logic [23:0] off, input logic last);
        in_valid = 1'b1; in_last = last; in_op = 2'b11; in_cond = 4'hE;
        in_cmd = 4'hF; in_s = 1'b1; in_rn = 4'hF; in_rd = 4'hF;
        in_rm = 4'hF; in_imm12 = 12'hFFF; in_imm24 = off;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst imem_we", 64'(imem_we), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst imem_addr", 64'(imem_addr), 64'd0);
        check("rst imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst count", 64'(count), 64'd0);
        #10;
        rst_n = 1'b1;

        // IDLE ignores in_valid.
        drive_add();
        step();
        check("idle no we", 64'(imem_we), 64'd0);
        check("idle in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // Single DP-imm ADD.
        pulse_start();
        check("load in_ready", 64'(in_ready), 64'd1);
        check("load count0", 64'(count), 64'd0);
        drive_add();
        step();
        in_valid = 1'b0;
        check("add we", 64'(imem_we), 64'd1);
        check("add addr", 64'(imem_addr), 64'd0);
        check("add wdata", 64'(imem_wdata), 64'hE2812005);
        check("add count", 64'(count), 64'd1);
        step();
        check("add we drop", 64'(imem_we), 64'd0);

        // LDR, STR, B back to back, from a fresh start.
        pulse_start();
        drive_mem(1'b1);
        step();
        check("ldr we", 64'(imem_we), 64'd1);
        check("ldr addr", 64'(imem_addr), 64'd0);
        check("ldr wdata", 64'(imem_wdata), 64'hE5934008);
        drive_mem(1'b0);
        step();
        check("str we", 64'(imem_we), 64'd1);
        check("str addr", 64'(imem_addr), 64'd1);
        check("str wdata", 64'(imem_wdata), 64'hE5834008);
        drive_b(24'hFFFFFE, 1'b1);
        step();
        check("b we", 64'(imem_we), 64'd1);
        check("b addr", 64'(imem_addr), 64'd2);
        check("b wdata", 64'(imem_wdata), 64'hEAFFFFFE);
        check("b in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        check("prog we drop", 64'(imem_we), 64'd0);
        check("prog done", 64'(done), 64'd1);
        check("prog count", 64'(count), 64'd3);

        // DONE ignores in_valid.
        drive_add();
        step();
        check("done no we", 64'(imem_we), 64'd0);
        check("done count hold", 64'(count), 64'd3);
        in_valid = 1'b0;

        // DP-reg SUBS r6, r5, r7 with cond EQ and a stray imm12.
        pulse_start();
        check("restart done clr", 64'(done), 64'd0);
        in_valid = 1'b1; in_last = 1'b1; in_op = 2'b00; in_cond = 4'h0;
        in_cmd = 4'h2; in_s = 1'b1; in_rn = 4'h5; in_rd = 4'h6; in_rm = 4'h7;
        in_imm12 = 12'hFFF; in_imm24 = 24'hFFFFFF;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("sub wdata", 64'(imem_wdata), 64'h00556007);
        check("sub addr", 64'(imem_addr), 64'd0);
        step();
        check("sub done", 64'(done), 64'd1);

        // Fill the whole memory with in_last=0.
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("fill ready %0d", i), 64'(in_ready), 64'd1);
            drive_b(24'(i), 1'b0);
            step();
            check($sformatf("fill we %0d", i), 64'(imem_we), 64'd1);
            check($sformatf("fill addr %0d", i), 64'(imem_addr), 64'(i));
            check($sformatf("fill wdata %0d", i), 64'(imem_wdata),
                  64'({8'hEA, 24'(i)}));
            check($sformatf("fill count %0d", i), 64'(count), 64'(i + 1));
        end
        check("full in_ready", 64'(in_ready), 64'd0);
        step();
        check("full no we", 64'(imem_we), 64'd0);
        check("full done", 64'(done), 64'd1);
        check("full count", 64'(count), 64'(DEPTH));
        step();
        check("full no we 2", 64'(imem_we), 64'd0);
        check("full count sat", 64'(count), 64'(DEPTH));

        // start together with in_valid while in DONE: start wins.
        drive_add();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start+valid no we", 64'(imem_we), 64'd0);
        check("start+valid count", 64'(count), 64'd0);
        check("start+valid ready", 64'(in_ready), 64'd1);
        step();
        check("after start we", 64'(imem_we), 64'd1);
        check("after start addr", 64'(imem_addr), 64'd0);
        check("after start wdata", 64'(imem_wdata), 64'hE2812005);
        check("after start count", 64'(count), 64'd1);

        // start while a write is pending: the write stays at its address.
        step();
        check("pend we", 64'(imem_we), 64'd1);
        check("pend addr", 64'(imem_addr), 64'd1);
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("pend restart we", 64'(imem_we), 64'd0);
        check("pend restart count", 64'(count), 64'd0);
        drive_add();
        step();
        check("pend next addr", 64'(imem_addr), 64'd0);
        check("pend next count", 64'(count), 64'd1);

        // Asynchronous reset with a write in flight.
        check("mid we before rst", 64'(imem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst we", 64'(imem_we), 64'd0);
        check("mid rst addr", 64'(imem_addr), 64'd0);
        check("mid rst wdata", 64'(imem_wdata), 64'd0);
        check("mid rst count", 64'(count), 64'd0);
        check("mid rst done", 64'(done), 64'd0);
        check("mid rst ready", 64'(in_ready), 64'd0);
        step();
        check("mid rst held we", 64'(imem_we), 64'd0);
        rst_n = 1'b1;
        step();
        check("post rst we", 64'(imem_we), 64'd0);
        check("post rst ready", 64'(in_ready), 64'd0);
        check("post rst count", 64'(count), 64'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
